// File: rtl/lbp_pkg.sv
// Shared constants, encodings and default weight sets for the LBP bilinear sampler.
package lbp_pkg;

  localparam int unsigned FRAC_W_DEF = 16;
  localparam int unsigned WGT_W_DEF  = FRAC_W_DEF + 1;
  localparam int unsigned WPROD_W    = 2 * WGT_W_DEF;

  // 1.0 in Q1.FRAC_W
  localparam logic [WGT_W_DEF-1:0] WGT_ONE = {1'b1, {FRAC_W_DEF{1'b0}}};

  // Weight-table field selector
  typedef enum logic [1:0] {
    SelA = 2'd0,
    SelB = 2'd1,
    SelC = 2'd2,
    SelD = 2'd3
  } cfg_sel_e;

  // Diagonal sample angles
  typedef enum logic [1:0] {
    Ang45  = 2'd0,
    Ang135 = 2'd1,
    Ang225 = 2'd2,
    Ang315 = 2'd3
  } diag_e;

  // Accumulator width: product width plus two bits of headroom for the 4-way sum
  function automatic int unsigned acc_w(int unsigned pix_w, int unsigned wgt_w);
    return pix_w + wgt_w + 2;
  endfunction

  // frac(R * cos 45deg) in Q0.16, rounded to nearest
  function automatic logic [FRAC_W_DEF-1:0] diag_frac(int unsigned r);
    case (r)
      2:       return 16'd27146;
      3:       return 16'd7951;
      4:       return 16'd54292;
      5:       return 16'd35097;
      6:       return 16'd15902;
      7:       return 16'd62243;
      8:       return 16'd43048;
      default: return '0;
    endcase
  endfunction

  // Default {wD, wC, wB, wA} for radius r at a diagonal angle; image y grows downwards.
  // Products are truncated, so the four weights may sum to slightly less than 1.0.
  function automatic logic [4*WGT_W_DEF-1:0] default_wgt(int unsigned r, diag_e ang);
    logic [WGT_W_DEF-1:0] f, g, fx, fy;
    logic [WPROD_W-1:0]   pa, pb, pc, pd;
    f = {1'b0, diag_frac(r)};
    g = WGT_ONE - f;
    case (ang)
      Ang45:   begin fx = f; fy = g; end
      Ang135:  begin fx = g; fy = g; end
      Ang225:  begin fx = g; fy = f; end
      default: begin fx = f; fy = f; end
    endcase
    pa = WPROD_W'(WGT_ONE - fx) * WPROD_W'(WGT_ONE - fy);
    pb = WPROD_W'(fx) * WPROD_W'(WGT_ONE - fy);
    pc = WPROD_W'(WGT_ONE - fx) * WPROD_W'(fy);
    pd = WPROD_W'(fx) * WPROD_W'(fy);
    return {pd[FRAC_W_DEF +: WGT_W_DEF], pc[FRAC_W_DEF +: WGT_W_DEF],
            pb[FRAC_W_DEF +: WGT_W_DEF], pa[FRAC_W_DEF +: WGT_W_DEF]};
  endfunction

endpackage

// File: rtl/lbp_weight_table.sv
// P-entry table of four bilinear weights; one write port, one combinational read port.
// Read data is packed {wD, wC, wB, wA}; out-of-range reads return all-zero weights.
module lbp_weight_table
  import lbp_pkg::*;
#(
  parameter int unsigned P      = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned WGT_W  = WGT_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [1:0]           wsel,
  input  logic [WGT_W-1:0]     wdata,
  input  logic [IDX_W-1:0]     raddr,
  output logic [4*WGT_W-1:0]   rdata
);

  localparam logic [WGT_W-1:0]   WgtOne = WGT_W'(1) << FRAC_W;
  localparam logic [4*WGT_W-1:0] DefSet = {{(3*WGT_W){1'b0}}, WgtOne};

  logic [4*WGT_W-1:0] mem_q [P];

  // Register file: reset to pass-through of A; addresses >= P match no entry and are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(P); i++) mem_q[i] <= DefSet;
    end else if (we) begin
      for (int i = 0; i < int'(P); i++) begin
        for (int k = 0; k < 4; k++) begin
          if (waddr == IDX_W'(i) && wsel == 2'(k)) mem_q[i][k*WGT_W +: WGT_W] <= wdata;
        end
      end
    end
  end

  // Combinational read, zero for unmatched index
  always_comb begin
    rdata = '0;
    for (int i = 0; i < int'(P); i++) begin
      if (raddr == IDX_W'(i)) rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/lbp_bilinear_interp.sv
// Streaming bilinear interpolator: out = sat(round(wA*A + wB*B + wC*C + wD*D)).
// Four-stage pipeline with a single global enable; a stalled output freezes every stage.
module lbp_bilinear_interp
  import lbp_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned P      = 8,
  parameter int unsigned WGT_W  = WGT_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  localparam int unsigned IDX_W = $clog2(P),
  localparam int unsigned ACC_W = acc_w(PIX_W, WGT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [PIX_W-1:0] A,
  input  logic [PIX_W-1:0] B,
  input  logic [PIX_W-1:0] C,
  input  logic [PIX_W-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [PIX_W-1:0] data_o,
  output logic [ACC_W-1:0] data_raw,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [1:0]       cfg_sel,
  input  logic [WGT_W-1:0] cfg_wdata
);

  localparam int unsigned    PROD_W = PIX_W + WGT_W;
  localparam int unsigned    SUM_W  = PROD_W + 1;
  localparam logic [ACC_W-1:0] RndHalf = ACC_W'(1) << (FRAC_W - 1);
  localparam logic [ACC_W-1:0] PixMax  = ACC_W'((1 << PIX_W) - 1);

  logic               adv;
  logic [4*WGT_W-1:0] lut_w;

  logic               v1_q, v2_q, v3_q, v4_q;
  logic [IDX_W-1:0]   idx1_q, idx2_q, idx3_q, idx4_q;
  logic [PIX_W-1:0]   pix1_q [4];
  logic [4*WGT_W-1:0] w1_q;
  logic [PROD_W-1:0]  prod_d [4];
  logic [PROD_W-1:0]  prod2_q [4];
  logic [SUM_W-1:0]   sum3_q [2];
  logic [ACC_W-1:0]   raw_d, rnd_d, shf_d, raw4_q;
  logic [PIX_W-1:0]   dat_d, dat4_q;

  assign adv       = ~(v4_q & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = v4_q;
  assign out_idx   = idx4_q;
  assign data_o    = dat4_q;
  assign data_raw  = raw4_q;

  // Lookup happens before the write lands, so a same-cycle write is seen by the next beat only
  lbp_weight_table #(
    .P      (P),
    .IDX_W  (IDX_W),
    .WGT_W  (WGT_W),
    .FRAC_W (FRAC_W)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wsel  (cfg_sel),
    .wdata (cfg_wdata),
    .raddr (in_idx),
    .rdata (lut_w)
  );

  // S2 products and S4 final sum with round-half-up and saturation
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      prod_d[k] = PROD_W'(pix1_q[k]) * PROD_W'(w1_q[k*WGT_W +: WGT_W]);
    end
    raw_d = ACC_W'(sum3_q[0]) + ACC_W'(sum3_q[1]);
    rnd_d = raw_d + RndHalf;
    shf_d = rnd_d >> FRAC_W;
    dat_d = (shf_d > PixMax) ? '1 : shf_d[PIX_W-1:0];
  end

  // S1: capture pixels, index and the weights latched for this beat
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      idx1_q <= '0;
      w1_q   <= '0;
      for (int k = 0; k < 4; k++) pix1_q[k] <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      idx1_q    <= in_idx;
      w1_q      <= lut_w;
      pix1_q[0] <= A;
      pix1_q[1] <= B;
      pix1_q[2] <= C;
      pix1_q[3] <= D;
    end
  end

  // S2: four products
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      idx2_q <= '0;
      for (int k = 0; k < 4; k++) prod2_q[k] <= '0;
    end else if (adv) begin
      v2_q   <= v1_q;
      idx2_q <= idx1_q;
      for (int k = 0; k < 4; k++) prod2_q[k] <= prod_d[k];
    end
  end

  // S3: pairwise sums (top row, bottom row)
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q      <= 1'b0;
      idx3_q    <= '0;
      sum3_q[0] <= '0;
      sum3_q[1] <= '0;
    end else if (adv) begin
      v3_q      <= v2_q;
      idx3_q    <= idx2_q;
      sum3_q[0] <= SUM_W'(prod2_q[0]) + SUM_W'(prod2_q[1]);
      sum3_q[1] <= SUM_W'(prod2_q[2]) + SUM_W'(prod2_q[3]);
    end
  end

  // S4: output register, held while downstream back-pressures
  always_ff @(posedge clk) begin
    if (rst) begin
      v4_q   <= 1'b0;
      idx4_q <= '0;
      raw4_q <= '0;
      dat4_q <= '0;
    end else if (adv) begin
      v4_q   <= v3_q;
      idx4_q <= idx3_q;
      raw4_q <= raw_d;
      dat4_q <= dat_d;
    end
  end

endmodule
